btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
- REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 16'd50000: stable-sample cycles required to accept a press or release (legal range 2..2^CNT_W-1).
- REQ-002 SHALL have parameter CNT_W, default 16: debounce counter width.
- REQ-003 SHALL have parameter LONG_TICKS, default 24'd6000000: held cycles before a long-press event (legal range 2..2^24-1).
- REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
- REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-006 SHALL have port btn_n, input, 1 bit: raw active-low pushbutton pin, asynchronous to clk.
- REQ-007 SHALL have port btn_level, output, 1 bit: debounced state, 1 = pressed.
- REQ-008 SHALL have port press_pulse, output, 1 bit: one-cycle strobe on accepted press.
- REQ-009 SHALL have port release_pulse, output, 1 bit: one-cycle strobe on accepted release.
- REQ-010 SHALL have port long_pulse, output, 1 bit: one-cycle strobe on long press.
- REQ-011 SHALL have port press_count, output, 8 bits: accepted presses since reset.

Function
- REQ-012 SHALL pass btn_n through a 2-flop synchronizer; the FSM uses only the second flop output (sync_n).
- REQ-013 SHALL implement states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT, with a CNT_W-bit debounce counter cleared on every state change.
- REQ-014 IDLE: sync_n=0 -> PRESS_WAIT; otherwise stay.
- REQ-015 PRESS_WAIT: sync_n=1 -> IDLE with no pulse (bounce rejected); counter==DEBOUNCE_TICKS-1 -> HELD; otherwise counter increments.
- REQ-016 HELD: sync_n=1 -> RELEASE_WAIT; otherwise stay.
- REQ-017 RELEASE_WAIT: sync_n=0 -> HELD with no pulse; counter==DEBOUNCE_TICKS-1 -> IDLE; otherwise counter increments.
- REQ-018 PRESS_WAIT->HELD SHALL, on the same edge, set btn_level=1, assert press_pulse for exactly one cycle, and increment press_count modulo 256 (255 wraps to 0).
- REQ-019 RELEASE_WAIT->IDLE SHALL, on the same edge, set btn_level=0 and assert release_pulse for exactly one cycle.
- REQ-020 Latency: if btn_n is first sampled low at edge 1 and stays low, press_pulse SHALL be high during the cycle after edge DEBOUNCE_TICKS+3; release latency SHALL be symmetric.
- REQ-021 All outputs SHALL be registered; press_pulse, release_pulse and long_pulse SHALL never be high in the same cycle.
- REQ-022 btn_level SHALL remain 1 throughout RELEASE_WAIT and 0 throughout PRESS_WAIT.

Reset
- REQ-023 While rst=1, the FSM SHALL be IDLE, both synchronizer flops 1, all counters 0, and btn_level, all pulses and press_count 0.
- REQ-024 Reset asserted mid-press SHALL abort the press with no pulses; after deassertion, a button still held SHALL be re-accepted after the full debounce latency of REQ-020.

Configuration
- REQ-025 Macro BTN_LONG_PRESS_EN defined: a 24-bit hold counter SHALL count HELD cycles, hold its value in RELEASE_WAIT, resume on return to HELD, and clear on entry to IDLE.
- REQ-026 With BTN_LONG_PRESS_EN defined, long_pulse SHALL assert for one cycle when the hold counter reaches LONG_TICKS-1, at most once per accepted press; the counter SHALL then saturate.
- REQ-027 Macro BTN_LONG_PRESS_EN undefined: the hold counter SHALL not be present and long_pulse SHALL be constant 0.

Verification (DEBOUNCE_TICKS=4, LONG_TICKS=16 unless noted)
- REQ-028 Clean press: btn_n 1->0 held 20 cycles -> press_pulse high only in the cycle after edge 7; btn_level 1 from then; press_count=1.
- REQ-029 Bounce: btn_n low 3 cycles, high 1, low 2, high -> no pulses, btn_level 0, press_count 0.
- REQ-030 Release glitch: held, then btn_n high 2 cycles, low again -> no release_pulse, no second press_pulse, btn_level stays 1.
- REQ-031 Wrap: 256 clean press/release pairs -> 256 press and 256 release pulses; press_count ends at 0.
- REQ-032 Long press, BTN_LONG_PRESS_EN defined: hold 40 cycles -> exactly one long_pulse, 16 cycles after press_pulse; with macro undefined, long_pulse stays 0.
- REQ-033 Reset mid-press: rst pulsed in PRESS_WAIT with btn_n held low -> outputs 0 during reset; press_pulse after edge 7 counted from first edge after deassertion.

Source files
------------

// File: rtl/btn_debounce.sv
// btn_debounce: synchronized, debounced pushbutton with press/release strobes and press counter.
// Define BTN_LONG_PRESS_EN to add a 24-bit hold counter and the long_pulse event.
module btn_debounce #(
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_TICKS = 16'd50000,
  parameter logic [23:0] LONG_TICKS = 24'd6000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_TICKS - 1'b1;
  state_t state, state_d;
  logic sync1, sync_n, at_last, accept, drop;
  logic [CNT_W-1:0] cnt;
  assign at_last = cnt == DB_LAST;
  assign accept = state == PRESS_WAIT && state_d == HELD;
  assign drop = state == RELEASE_WAIT && state_d == IDLE;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:         state_d = sync_n ? IDLE : PRESS_WAIT;
      PRESS_WAIT:   state_d = sync_n ? IDLE : at_last ? HELD : PRESS_WAIT;
      HELD:         state_d = sync_n ? RELEASE_WAIT : HELD;
      RELEASE_WAIT: state_d = !sync_n ? HELD : at_last ? IDLE : RELEASE_WAIT;
      default:      state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync_n <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      btn_level <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      press_count <= '0;
    end else begin
      sync1 <= btn_n;
      sync_n <= sync1;
      state <= state_d;
      cnt <= state_d != state ? '0 : (state == PRESS_WAIT || state == RELEASE_WAIT) ? cnt + 1'b1 : cnt;
      btn_level <= accept ? 1'b1 : drop ? 1'b0 : btn_level;
      press_pulse <= accept;
      release_pulse <= drop;
      press_count <= press_count + {7'd0, accept};
    end
  end
`ifdef BTN_LONG_PRESS_EN
  localparam logic [23:0] LONG_LAST = LONG_TICKS - 1'b1;
  logic [23:0] hold_cnt;
  // Saturating at LONG_TICKS guarantees a single long_pulse per accepted press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= state == HELD && hold_cnt == LONG_LAST;
      hold_cnt <= state_d == IDLE ? '0 : (state == HELD && hold_cnt != LONG_TICKS) ? hold_cnt + 1'b1 : hold_cnt;
    end
  end
`else
  assign long_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed checks of btn_debounce with DEBOUNCE_TICKS=4, LONG_TICKS=16.
module tb_btn_debounce;
  logic clk = 1'b0, rst = 1'b1, btn_n = 1'b1;
  logic btn_level, press_pulse, release_pulse, long_pulse;
  logic [7:0] press_count;
  int checks = 0, failures = 0;
  int edge_n = 0, n_press = 0, n_rel = 0, n_long = 0, n_excl = 0, n_rst_out = 0;
  int press_edge = 0, long_edge = 0;
  int e0, p0, r0, l0;

  btn_debounce #(.CNT_W(16), .DEBOUNCE_TICKS(16'd4), .LONG_TICKS(24'd16)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .press_count(press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  always @(negedge clk) begin
    if (press_pulse) begin n_press++; press_edge = edge_n; end
    if (release_pulse) n_rel++;
    if (long_pulse) begin n_long++; long_edge = edge_n; end
    if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) > 1) n_excl++;
    if (rst && (btn_level || press_pulse || release_pulse || long_pulse || press_count != 0)) n_rst_out++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    e0 = edge_n; p0 = n_press; r0 = n_rel; l0 = n_long;
  endtask

  initial begin
    tick(3);
    @(negedge clk);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_count", int'(press_count), 0);
    chk("rst_pulses", int'(press_pulse) + int'(release_pulse) + int'(long_pulse), 0);
    tick(1);
    rst = 1'b0;
    tick(3);
    // bounce: low 3, high 1, low 2, high
    mark();
    btn_n = 1'b0; tick(3); btn_n = 1'b1; tick(1); btn_n = 1'b0; tick(2); btn_n = 1'b1; tick(12);
    chk("bounce_press", n_press - p0, 0);
    chk("bounce_rel", n_rel - r0, 0);
    chk("bounce_level", int'(btn_level), 0);
    chk("bounce_count", int'(press_count), 0);
    // clean press
    mark();
    btn_n = 1'b0; tick(20);
    chk("press_n", n_press - p0, 1);
    chk("press_lat", press_edge - e0, 7);
    chk("press_level", int'(btn_level), 1);
    chk("press_count1", int'(press_count), 1);
    // release glitch
    mark();
    btn_n = 1'b1; tick(2); btn_n = 1'b0; tick(1);
    @(negedge clk);
    chk("glitch_level_rw", int'(btn_level), 1);
    tick(10);
    chk("glitch_rel", n_rel - r0, 0);
    chk("glitch_press", n_press - p0, 0);
    chk("glitch_level", int'(btn_level), 1);
    // clean release
    mark();
    btn_n = 1'b1; tick(4);
    @(negedge clk);
    chk("rw_level", int'(btn_level), 1);
    tick(12);
    chk("rel_n", n_rel - r0, 1);
    chk("rel_level", int'(btn_level), 0);
    chk("rel_count", int'(press_count), 1);
    // long press
    mark();
    btn_n = 1'b0; tick(40);
    chk("long_press_n", n_press - p0, 1);
`ifdef BTN_LONG_PRESS_EN
    chk("long_n", n_long - l0, 1);
    chk("long_lat", long_edge - press_edge, 16);
`else
    chk("long_n", n_long - l0, 0);
`endif
    btn_n = 1'b1; tick(15);
    chk("long_rel", n_rel - r0, 1);
    // reset mid-press
    mark();
    btn_n = 1'b0; tick(4);
    rst = 1'b1; tick(1);
    @(negedge clk);
    chk("mid_rst_level", int'(btn_level), 0);
    chk("mid_rst_count", int'(press_count), 0);
    tick(2);
    chk("mid_rst_nopress", n_press - p0, 0);
    rst = 1'b0;
    mark();
    tick(12);
    chk("mid_rst_press", n_press - p0, 1);
    chk("mid_rst_lat", press_edge - e0, 7);
    chk("mid_rst_count1", int'(press_count), 1);
    // wrap after a clean reset
    btn_n = 1'b1; rst = 1'b1; tick(2); rst = 1'b0; tick(4);
    mark();
    for (int i = 0; i < 256; i++) begin
      btn_n = 1'b0; tick(10);
      btn_n = 1'b1; tick(10);
    end
    tick(5);
    chk("wrap_press", n_press - p0, 256);
    chk("wrap_rel", n_rel - r0, 256);
    chk("wrap_count", int'(press_count), 0);
    chk("wrap_level", int'(btn_level), 0);
`ifndef BTN_LONG_PRESS_EN
    chk("long_never", n_long, 0);
`endif
    chk("pulse_exclusive", n_excl, 0);
    chk("rst_outputs_zero", n_rst_out, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
